r2sdf_twiddle_mult16: RTL and testbench

Initiator side of the 16-point twiddle table interface, sitting between the second and third butterfly stages of the 16-point R2SDF pipeline.
- Tracks the sample index of the incoming stream and drives the twiddle address.
- Takes the returned twiddle after the table's configured latency and complex-multiplies it with the time-aligned sample.
- Emits the rounded, saturated Q1.15 product stream.

---
 rtl/r2sdf_twiddle_mult16.sv | 201 ++++++++++++++++++++
 tb/tb_r2sdf_twiddle_mult16.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/r2sdf_twiddle_mult16.sv
`default_nettype none
// ============================================================================
// Module   : r2sdf_twiddle_mult16
// Purpose  : Twiddle-table initiator for the 16-point R2SDF pipeline, placed
//            between butterfly stages 2 and 3. Tracks the sample index,
//            drives the twiddle address, aligns the sample with the returned
//            twiddle, complex-multiplies, and rounds/saturates to Q1.15.
// Ports    : clk             clock, rising edge
//            rst             asynchronous active-high reset
//            di_en           input sample valid
//            di_re / di_im   input sample, Q1.15
//            tw_addr         twiddle table address (0..9)
//            tw_re / tw_im   twiddle returned by the table, TW_FF cycles later
//            do_en           output sample valid (TW_FF+2 cycles after di_en)
//            do_re / do_im   output sample, Q1.15, held while do_en=0
// Revision : 1.0 - initial release
// ============================================================================
module r2sdf_twiddle_mult16 #(
  parameter int TW_FF = 1,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             di_en,
  input  logic [WIDTH-1:0] di_re,
  input  logic [WIDTH-1:0] di_im,
  output logic [3:0]       tw_addr,
  input  logic [WIDTH-1:0] tw_re,
  input  logic [WIDTH-1:0] tw_im,
  output logic             do_en,
  output logic [WIDTH-1:0] do_re,
  output logic [WIDTH-1:0] do_im
);

  localparam int PW = 2 * WIDTH + 1;

  // Rounding offset 2^(WIDTH-2) and saturation bounds, all PW bits signed.
  localparam logic signed [PW-1:0] c_rnd = {{(WIDTH+2){1'b0}}, 1'b1, {(WIDTH-2){1'b0}}};
  localparam logic signed [PW-1:0] c_max = {{(WIDTH+2){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [PW-1:0] c_min = {{(WIDTH+2){1'b1}}, {(WIDTH-1){1'b0}}};

  // --------------------------------------------------------------------------
  // Sample counter and address generation
  // --------------------------------------------------------------------------
  logic [3:0] r_cnt;
  logic [3:0] w_tw_addr;
  logic       w_bypass;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= 4'd0;
    end else if (di_en) begin
      r_cnt <= r_cnt + 4'd1;
    end
  end

  // The stage-3 twiddle exponent is the bit-reversed upper index pair times
  // the lower index pair: {cnt[2],cnt[3]} * cnt[1:0].
  assign w_tw_addr = {2'b00, r_cnt[2], r_cnt[3]} * {2'b00, r_cnt[1:0]};
  assign tw_addr   = w_tw_addr;
  // W0 is approximated as 0x7FFF in the table, so it is bypassed exactly.
  assign w_bypass  = (w_tw_addr == 4'd0);

  // --------------------------------------------------------------------------
  // Alignment: delay sample, valid and bypass flag by the table latency
  // --------------------------------------------------------------------------
  logic             w_a_en;
  logic             w_a_byp;
  logic [WIDTH-1:0] w_a_re;
  logic [WIDTH-1:0] w_a_im;

  generate
    if (TW_FF == 0) begin : g_align_comb
      assign w_a_en  = di_en;
      assign w_a_byp = w_bypass;
      assign w_a_re  = di_re;
      assign w_a_im  = di_im;
    end else begin : g_align_reg
      logic [TW_FF-1:0] r_en_sr;
      logic [TW_FF-1:0] r_byp_sr;
      logic [WIDTH-1:0] r_re_sr [TW_FF];
      logic [WIDTH-1:0] r_im_sr [TW_FF];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_en_sr  <= '0;
          r_byp_sr <= '0;
          for (int i = 0; i < TW_FF; i++) begin
            r_re_sr[i] <= '0;
            r_im_sr[i] <= '0;
          end
        end else begin
          r_en_sr[0]  <= di_en;
          r_byp_sr[0] <= w_bypass;
          r_re_sr[0]  <= di_re;
          r_im_sr[0]  <= di_im;
          for (int i = 1; i < TW_FF; i++) begin
            r_en_sr[i]  <= r_en_sr[i-1];
            r_byp_sr[i] <= r_byp_sr[i-1];
            r_re_sr[i]  <= r_re_sr[i-1];
            r_im_sr[i]  <= r_im_sr[i-1];
          end
        end
      end

      assign w_a_en  = r_en_sr[TW_FF-1];
      assign w_a_byp = r_byp_sr[TW_FF-1];
      assign w_a_re  = r_re_sr[TW_FF-1];
      assign w_a_im  = r_im_sr[TW_FF-1];
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Complex multiply
  // --------------------------------------------------------------------------
  logic signed [2*WIDTH-1:0] w_p_rr;
  logic signed [2*WIDTH-1:0] w_p_ii;
  logic signed [2*WIDTH-1:0] w_p_ri;
  logic signed [2*WIDTH-1:0] w_p_ir;
  logic signed [PW-1:0]      w_pr;
  logic signed [PW-1:0]      w_pi;

  assign w_p_rr = $signed(w_a_re) * $signed(tw_re);
  assign w_p_ii = $signed(w_a_im) * $signed(tw_im);
  assign w_p_ri = $signed(w_a_re) * $signed(tw_im);
  assign w_p_ir = $signed(w_a_im) * $signed(tw_re);

  // One guard bit keeps the sum/difference of two full products exact.
  assign w_pr = $signed({w_p_rr[2*WIDTH-1], w_p_rr}) - $signed({w_p_ii[2*WIDTH-1], w_p_ii});
  assign w_pi = $signed({w_p_ri[2*WIDTH-1], w_p_ri}) + $signed({w_p_ir[2*WIDTH-1], w_p_ir});

  logic                 r_m_en;
  logic                 r_m_byp;
  logic signed [PW-1:0] r_m_pr;
  logic signed [PW-1:0] r_m_pi;
  logic [WIDTH-1:0]     r_m_re;
  logic [WIDTH-1:0]     r_m_im;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_m_en  <= 1'b0;
      r_m_byp <= 1'b0;
      r_m_pr  <= '0;
      r_m_pi  <= '0;
      r_m_re  <= '0;
      r_m_im  <= '0;
    end else begin
      r_m_en <= w_a_en;
      // Data registers only load on valid samples to avoid idle toggling.
      if (w_a_en) begin
        r_m_byp <= w_a_byp;
        r_m_pr  <= w_pr;
        r_m_pi  <= w_pi;
        r_m_re  <= w_a_re;
        r_m_im  <= w_a_im;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Round half-up, shift back to Q1.15, saturate
  // --------------------------------------------------------------------------
  function automatic logic [WIDTH-1:0] f_rnd_sat(input logic signed [PW-1:0] v);
    logic signed [PW-1:0] v_rnd;
    logic signed [PW-1:0] v_shr;
    logic [WIDTH-1:0]     res;
    v_rnd = v + c_rnd;
    v_shr = v_rnd >>> (WIDTH - 1);
    if (v_shr > c_max) begin
      res = {1'b0, {(WIDTH-1){1'b1}}};
    end else if (v_shr < c_min) begin
      res = {1'b1, {(WIDTH-1){1'b0}}};
    end else begin
      res = v_shr[WIDTH-1:0];
    end
    return res;
  endfunction

  logic [WIDTH-1:0] w_o_re;
  logic [WIDTH-1:0] w_o_im;

  assign w_o_re = r_m_byp ? r_m_re : f_rnd_sat(r_m_pr);
  assign w_o_im = r_m_byp ? r_m_im : f_rnd_sat(r_m_pi);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      do_en <= 1'b0;
      do_re <= '0;
      do_im <= '0;
    end else begin
      do_en <= r_m_en;
      // Outputs hold the last valid sample across gaps.
      if (r_m_en) begin
        do_re <= w_o_re;
        do_im <= w_o_im;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_r2sdf_twiddle_mult16.sv
`default_nettype none
// ============================================================================
// Module   : tb_r2sdf_twiddle_mult16
// Purpose  : Scoreboard bench for r2sdf_twiddle_mult16 with a registered
//            twiddle table model (TW_FF = 1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_r2sdf_twiddle_mult16;

  localparam int TW_FF = 1;
  localparam int WIDTH = 16;
  localparam int LAT   = TW_FF + 2;

  // W^k = exp(-j*2*pi*k/16) in Q1.15, entries 0..9 used.
  localparam logic [15:0] TBL_RE [16] = '{16'h7FFF, 16'h7642, 16'h5A82, 16'h30FC,
                                          16'h0000, 16'hCF04, 16'hA57E, 16'h89BE,
                                          16'h8001, 16'h89BE, 16'h0000, 16'h0000,
                                          16'h0000, 16'h0000, 16'h0000, 16'h0000};
  localparam logic [15:0] TBL_IM [16] = '{16'h0000, 16'hCF04, 16'hA57E, 16'h89BE,
                                          16'h8001, 16'h89BE, 16'hA57E, 16'hCF04,
                                          16'h0000, 16'h30FC, 16'h0000, 16'h0000,
                                          16'h0000, 16'h0000, 16'h0000, 16'h0000};
  localparam int ADDR_SEQ [16] = '{0, 0, 0, 0, 0, 2, 4, 6, 0, 1, 2, 3, 0, 3, 6, 9};

  logic             clk;
  logic             rst;
  logic             di_en;
  logic [WIDTH-1:0] di_re;
  logic [WIDTH-1:0] di_im;
  logic [3:0]       tw_addr;
  logic [WIDTH-1:0] tw_re;
  logic [WIDTH-1:0] tw_im;
  logic             do_en;
  logic [WIDTH-1:0] do_re;
  logic [WIDTH-1:0] do_im;

  r2sdf_twiddle_mult16 #(
    .TW_FF (TW_FF),
    .WIDTH (WIDTH)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .di_en   (di_en),
    .di_re   (di_re),
    .di_im   (di_im),
    .tw_addr (tw_addr),
    .tw_re   (tw_re),
    .tw_im   (tw_im),
    .do_en   (do_en),
    .do_re   (do_re),
    .do_im   (do_im)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Registered twiddle table.
  always @(posedge clk) begin
    tw_re <= TBL_RE[tw_addr];
    tw_im <= TBL_IM[tw_addr];
  end

  typedef struct {
    logic [15:0] re;
    logic [15:0] im;
    int          cyc;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   model_idx = 0;
  int   exp_addr = 0;
  bit   done = 1'b0;

  // ---------------------------------------------------------------------
  // Reference model: plain integer arithmetic
  // ---------------------------------------------------------------------
  function automatic logic [15:0] rnd_sat(longint v);
    longint r;
    r = (v + 64'sd16384) >>> 15;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    return 16'(r);
  endfunction

  function automatic logic [31:0] model(int k, logic [15:0] re, logic [15:0] im);
    longint ar, ai, wr, wi;
    if (k == 0) return {re, im};
    ar = longint'($signed(re));
    ai = longint'($signed(im));
    wr = longint'($signed(TBL_RE[k]));
    wi = longint'($signed(TBL_IM[k]));
    return {rnd_sat(ar * wr - ai * wi), rnd_sat(ar * wi + ai * wr)};
  endfunction

  function automatic logic [15:0] rdata();
    case ($urandom_range(0, 4))
      0:       return 16'h8000;
      1:       return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  // ---------------------------------------------------------------------
  // Driver: one call = one clock cycle
  // ---------------------------------------------------------------------
  task automatic send_x(input bit en, input logic [15:0] re, input logic [15:0] im,
                        input bit lit, input logic [15:0] lre, input logic [15:0] lim);
    exp_t        e;
    logic [31:0] m;
    @(posedge clk);
    #1;
    di_en = en;
    di_re = re;
    di_im = im;
    if (en) begin
      exp_addr = ADDR_SEQ[model_idx];
      m        = model(ADDR_SEQ[model_idx], re, im);
      e.re     = lit ? lre : m[31:16];
      e.im     = lit ? lim : m[15:0];
      e.cyc    = cyc + LAT;
      sb_q.push_back(e);
      model_idx = (model_idx + 1) % 16;
    end
  endtask

  task automatic send(input bit en);
    send_x(en, rdata(), rdata(), 1'b0, 16'h0, 16'h0);
  endtask

  // ---------------------------------------------------------------------
  // Monitor / scoreboard: sole owner of the check counters
  // ---------------------------------------------------------------------
  logic [15:0] hold_re = 16'h0;
  logic [15:0] hold_im = 16'h0;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h, want %h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      cmp("reset_outputs", {31'd0, do_en, do_re, do_im}, 64'd0);
      sb_q.delete();
      hold_re = 16'h0;
      hold_im = 16'h0;
    end else begin
      if (di_en) cmp("tw_addr", 64'(tw_addr), 64'(exp_addr));
      if (do_en) begin
        if (sb_q.size() == 0) begin
          cmp("stray_do_en", 64'd1, 64'd0);
        end else begin
          e = sb_q.pop_front();
          cmp("do_data", {32'd0, do_re, do_im}, {32'd0, e.re, e.im});
          cmp("latency_cycle", 64'(cyc), 64'(e.cyc));
          hold_re = e.re;
          hold_im = e.im;
        end
      end else begin
        cmp("hold_value", {32'd0, do_re, do_im}, {32'd0, hold_re, hold_im});
      end
    end
    if (done) begin
      cmp("queue_drained", 64'(sb_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1, "timeout");
  end

  // ---------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------
  initial begin
    rst   = 1'b1;
    di_en = 1'b0;
    di_re = '0;
    di_im = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Two full frames: address sequence repeats identically.
    for (int i = 0; i < 32; i++) send(1'b1);

    // Directed known values on a fresh frame.
    send_x(1'b1, 16'h8000, 16'h1234, 1'b1, 16'h8000, 16'h1234);   // idx 0 bypass
    for (int i = 1; i < 5; i++) send(1'b1);
    send_x(1'b1, 16'h4000, 16'h0000, 1'b1, 16'h2D41, 16'hD2BF);   // idx 5, W2
    send(1'b1);
    send_x(1'b1, 16'h8000, 16'h8000, 1'b1, 16'h0000, 16'h7FFF);   // idx 7, W6
    for (int i = 8; i < 16; i++) send(1'b1);

    // Gap pattern 1,0,0,1,1,0,1 across indices 4..7.
    for (int i = 0; i < 4; i++) send(1'b1);
    send(1'b1); send(1'b0); send(1'b0); send(1'b1);
    send(1'b1); send(1'b0); send(1'b1);
    for (int i = 8; i < 16; i++) send(1'b1);

    // Randomized traffic with random gaps.
    for (int i = 0; i < 400; i++) send($urandom_range(0, 3) != 0);

    // Reset mid-frame at sample index 9 with samples in flight.
    while (model_idx != 9) send(1'b1);
    send(1'b1);
    @(posedge clk);
    #1;
    rst       = 1'b1;
    di_en     = 1'b0;
    model_idx = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 20; i++) send(1'b1);
    for (int i = 0; i < 8; i++) send(1'b0);
    done = 1'b1;
  end

endmodule
`default_nettype wire
